// File: rtl/pcie_vc_router.sv
// pcie_vc_router: header-steered virtual-channel FIFOs drained by an arbiter into
// per-destination FIFOs, with pause flags and an init/idle/active/error control FSM.
// Build option: define VC_STRICT_PRIO_EN for lowest-index-first arbitration instead of round-robin.
module pcie_vc_router #(
  parameter int DATA_W     = 6,
  parameter int NUM_VC     = 2,
  parameter int NUM_DEST   = 2,
  parameter int VC_DEPTH   = 16,
  parameter int DEST_DEPTH = 4,
  localparam int VC_W    = $clog2(NUM_VC),
  localparam int DEST_W  = $clog2(NUM_DEST),
  localparam int VC_CW   = $clog2(VC_DEPTH) + 1,
  localparam int DEST_CW = $clog2(DEST_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       init,
  input  logic [VC_CW-1:0]           umbral_vc,
  input  logic [DEST_CW-1:0]         umbral_dest,
  input  logic                       push,
  input  logic [DATA_W-1:0]          data_in,
  input  logic [NUM_DEST-1:0]        pop,
  output logic [NUM_DEST*DATA_W-1:0] data_out,
  output logic [NUM_DEST-1:0]        valid_out,
  output logic [NUM_VC-1:0]          pause_vc,
  output logic [NUM_DEST-1:0]        dest_empty,
  output logic                       active_out,
  output logic                       idle_out,
  output logic                       error_out
);
  localparam int VC_AW   = $clog2(VC_DEPTH);
  localparam int DEST_AW = $clog2(DEST_DEPTH);
  localparam logic [VC_CW-1:0]   VC_FULL   = VC_CW'(VC_DEPTH);
  localparam logic [DEST_CW-1:0] DEST_FULL = DEST_CW'(DEST_DEPTH);

  typedef enum logic [2:0] {ST_RESET, ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR} state_t;
  state_t state_q, state_d;

  logic [VC_CW-1:0]   thr_vc_q;
  logic [DEST_CW-1:0] thr_dest_q;

  logic [DATA_W-1:0]  vc_mem      [NUM_VC][VC_DEPTH];
  logic [VC_AW-1:0]   vc_wr_ptr   [NUM_VC];
  logic [VC_AW-1:0]   vc_rd_ptr   [NUM_VC];
  logic [VC_CW-1:0]   vc_cnt      [NUM_VC];

  logic [DATA_W-1:0]  dest_mem    [NUM_DEST][DEST_DEPTH];
  logic [DEST_AW-1:0] dest_wr_ptr [NUM_DEST];
  logic [DEST_AW-1:0] dest_rd_ptr [NUM_DEST];
  logic [DEST_CW-1:0] dest_cnt    [NUM_DEST];

  logic                running;
  logic                pop_open;
  logic [VC_W-1:0]     push_vc;
  logic                push_ok;
  logic                push_err;
  logic                pop_err;
  logic                all_empty;
  logic                err_event;
  logic [NUM_DEST-1:0] pop_ok;
  logic [NUM_VC-1:0]   eligible;
  logic [DEST_W-1:0]   head_dest [NUM_VC];
  logic                grant_valid;
  logic [VC_W-1:0]     grant_vc;
  logic [DATA_W-1:0]   grant_word;
  logic [DEST_W-1:0]   grant_dest;
  logic [NUM_VC-1:0]   vc_wr;
  logic [NUM_VC-1:0]   vc_rd;
  logic [NUM_DEST-1:0] dest_wr;

  assign running  = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign pop_open = running || (state_q == ST_ERROR);
  assign push_vc  = data_in[DATA_W-1 -: VC_W];

  // A VC may only move its head forward when the target destination is below threshold.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      head_dest[v] = vc_mem[v][vc_rd_ptr[v]][DATA_W-1-VC_W -: DEST_W];
      eligible[v]  = running && (vc_cnt[v] != '0)
                  && (dest_cnt[head_dest[v]] < thr_dest_q)
                  && (dest_cnt[head_dest[v]] != DEST_FULL);
    end
  end

`ifndef VC_STRICT_PRIO_EN
  logic [VC_W-1:0] last_grant_q;

  always_ff @(posedge clk) begin
    if (reset)            last_grant_q <= VC_W'(NUM_VC - 1);
    else if (grant_valid) last_grant_q <= grant_vc;
  end
`endif

  always_comb begin
    grant_valid = 1'b0;
    grant_vc    = '0;
`ifdef VC_STRICT_PRIO_EN
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        grant_valid = 1'b1;
        grant_vc    = VC_W'(i);
      end
    end
`else
    // Scan from farthest to nearest offset so the VC just after last_grant wins.
    for (int i = NUM_VC; i >= 1; i--) begin
      if (eligible[last_grant_q + VC_W'(i)]) begin
        grant_valid = 1'b1;
        grant_vc    = last_grant_q + VC_W'(i);
      end
    end
`endif
  end

  assign grant_word = vc_mem[grant_vc][vc_rd_ptr[grant_vc]];
  assign grant_dest = head_dest[grant_vc];

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    push_ok   = 1'b0;
    push_err  = 1'b0;
    pop_err   = 1'b0;
    all_empty = 1'b1;
    pop_ok    = '0;
    vc_wr     = '0;
    vc_rd     = '0;
    dest_wr   = '0;
    if (running && push) begin
      if ((vc_cnt[push_vc] != VC_FULL) || (grant_valid && (grant_vc == push_vc))) push_ok = 1'b1;
      else                                                                         push_err = 1'b1;
    end
    for (int v = 0; v < NUM_VC; v++) begin
      vc_wr[v] = push_ok && (push_vc == VC_W'(v));
      vc_rd[v] = grant_valid && (grant_vc == VC_W'(v));
      if (vc_cnt[v] != '0) all_empty = 1'b0;
    end
    for (int d = 0; d < NUM_DEST; d++) begin
      pop_ok[d]  = pop_open && pop[d] && (dest_cnt[d] != '0);
      dest_wr[d] = grant_valid && (grant_dest == DEST_W'(d));
      if (running && pop[d] && (dest_cnt[d] == '0)) pop_err = 1'b1;
      if (dest_cnt[d] != '0) all_empty = 1'b0;
    end
  end

  assign err_event = push_err || pop_err;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (err_event) state_d = ST_ERROR;
        else if (init) state_d = ST_INIT;
        else if (push) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (err_event)                state_d = ST_ERROR;
        else if (init)                state_d = ST_INIT;
        else if (all_empty && !push)  state_d = ST_IDLE;
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RESET;
      thr_vc_q   <= VC_CW'(VC_DEPTH - 2);
      thr_dest_q <= DEST_CW'(DEST_DEPTH - 1);
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) begin
        thr_vc_q   <= umbral_vc;
        thr_dest_q <= umbral_dest;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        vc_wr_ptr[v] <= '0;
        vc_rd_ptr[v] <= '0;
        vc_cnt[v]    <= '0;
      end
      for (int d = 0; d < NUM_DEST; d++) begin
        dest_wr_ptr[d] <= '0;
        dest_rd_ptr[d] <= '0;
        dest_cnt[d]    <= '0;
      end
      data_out  <= '0;
      valid_out <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (vc_wr[v]) vc_wr_ptr[v] <= vc_wr_ptr[v] + VC_AW'(1);
        if (vc_rd[v]) vc_rd_ptr[v] <= vc_rd_ptr[v] + VC_AW'(1);
        vc_cnt[v] <= vc_cnt[v] + VC_CW'(vc_wr[v]) - VC_CW'(vc_rd[v]);
      end
      for (int d = 0; d < NUM_DEST; d++) begin
        if (dest_wr[d]) dest_wr_ptr[d] <= dest_wr_ptr[d] + DEST_AW'(1);
        if (pop_ok[d]) begin
          dest_rd_ptr[d]                <= dest_rd_ptr[d] + DEST_AW'(1);
          data_out[d*DATA_W +: DATA_W]  <= dest_mem[d][dest_rd_ptr[d]];
        end
        dest_cnt[d] <= dest_cnt[d] + DEST_CW'(dest_wr[d]) - DEST_CW'(pop_ok[d]);
      end
      valid_out <= pop_ok;
    end
  end

  // NOTE: storage arrays are not reset; zeroed pointers and counts make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push_ok)     vc_mem[push_vc][vc_wr_ptr[push_vc]] <= data_in;
    if (grant_valid) dest_mem[grant_dest][dest_wr_ptr[grant_dest]] <= grant_word;
  end

  always_comb begin
    for (int v = 0; v < NUM_VC; v++)   pause_vc[v]   = (vc_cnt[v] >= thr_vc_q);
    for (int d = 0; d < NUM_DEST; d++) dest_empty[d] = (dest_cnt[d] == '0);
  end

  assign active_out = (state_q == ST_ACTIVE);
  assign idle_out   = (state_q == ST_IDLE);
  assign error_out  = (state_q == ST_ERROR);

endmodule
